// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the writeback stage: result-source selects, load funct3 codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package writeback_unit_pkg;

    // Result source select carried with each retiring instruction; 2'b11 is reserved and behaves as ALU.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Load widths as encoded in funct3; any other code is handled as a full word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load aligner: extracts and sign/zero-extends a byte, halfword or word from a raw memory word.
// Latency: purely combinational.
// Backpressure: none.
module writeback_unit_load_align
    import writeback_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the word.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend according to load type; unknown funct3 falls through to the word path.
    always_comb begin
        o_data       = i_rdata;
        o_misaligned = (i_addr != 2'b00);
        case (i_funct3)
            F3_LB: begin
                o_data       = {{24{w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            F3_LBU: begin
                o_data       = {24'd0, w_byte};
                o_misaligned = 1'b0;
            end
            F3_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr[0];
            end
            F3_LHU: begin
                o_data       = {16'd0, w_half};
                o_misaligned = i_addr[0];
            end
            default: begin
                o_data       = i_rdata;
                o_misaligned = (i_addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires one instruction per handshake into the register-file write port (optional WB_RETIRE_COUNT_EN adds retired_count).
// Latency: 1 cycle accept->commit for ALU/PC4; loads commit the cycle after mem_rvalid.
// Backpressure: in_ready low only while waiting for load data; COMMIT accepts back-to-back.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   WR3,
    output logic              writeRegister,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]       retired_count,
`endif
    output logic              misalign
);

    wb_state_t         r_state;
    wb_state_t         w_next_state;
    logic              w_accept;
    logic              w_load_done;
    logic              w_we;
    logic              w_fwd_valid;

    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [REG_AW-1:0] r_a3;
    logic [XLEN-1:0]   r_wr3;
    logic              r_cur_misaligned;
    logic              r_misalign;

    logic [XLEN-1:0]   w_ld_data;
    logic              w_ld_misaligned;

    writeback_unit_load_align u_load_align (
        .i_rdata      (mem_rdata),
        .i_addr       (r_addr_lo),
        .i_funct3     (r_funct3),
        .o_data       (w_ld_data),
        .o_misaligned (w_ld_misaligned)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, handshake and write-port qualifiers.
    always_comb begin
        w_next_state = r_state;
        in_ready     = (r_state != S_WAIT_MEM);
        w_accept     = in_valid && (r_state != S_WAIT_MEM);
        w_load_done  = 1'b0;
        w_we         = 1'b0;
        w_fwd_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (in_wb_sel == WB_MEM) ? S_WAIT_MEM : S_COMMIT;
                end
            end
            S_WAIT_MEM: begin
                w_fwd_valid = r_reg_write && (r_rd != '0);
                if (mem_rvalid) begin
                    w_load_done  = 1'b1;
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_fwd_valid = r_reg_write && (r_rd != '0);
                w_we        = r_reg_write && (r_rd != '0) && !r_cur_misaligned;
                if (w_accept) begin
                    w_next_state = (in_wb_sel == WB_MEM) ? S_WAIT_MEM : S_COMMIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch the accepted instruction; load the write port on the way into COMMIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd             <= '0;
            r_reg_write      <= 1'b0;
            r_funct3         <= 3'd0;
            r_addr_lo        <= 2'd0;
            r_a3             <= '0;
            r_wr3            <= '0;
            r_cur_misaligned <= 1'b0;
            r_misalign       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd             <= in_rd;
                r_reg_write      <= in_reg_write;
                r_funct3         <= in_funct3;
                r_addr_lo        <= in_alu_result[1:0];
                r_cur_misaligned <= 1'b0;
                if (in_wb_sel != WB_MEM) begin
                    r_a3  <= in_rd;
                    r_wr3 <= (in_wb_sel == WB_PC4) ? in_pc4 : in_alu_result;
                end
            end
            if (w_load_done) begin
                r_a3             <= r_rd;
                r_wr3            <= w_ld_data;
                r_cur_misaligned <= w_ld_misaligned;
                if (w_ld_misaligned) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] r_retired;

    // Count every COMMIT cycle, suppressed writes included; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (r_state == S_COMMIT) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired_count = r_retired;
`endif

    assign A3            = r_a3;
    assign WR3           = r_wr3;
    assign writeRegister = w_we;
    assign fwd_valid     = w_fwd_valid;
    assign fwd_rd        = r_rd;
    assign misalign      = r_misalign;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed cases then randomized instruction stream vs. a transaction-level model.
// Latency: expectations derived from accept/rvalid timing rules.
// Backpressure: in_ready checked low during load waits, high otherwise.
module tb_writeback_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  A3;
    logic [31:0] WR3;
    logic        writeRegister;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic        misalign;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    writeback_unit dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc4        (in_pc4),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .A3            (A3),
        .WR3           (WR3),
        .writeRegister (writeRegister),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
`ifdef WB_RETIRE_COUNT_EN
        .retired_count (retired_count),
`endif
        .misalign      (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] mdata;
        int          lat;
    } instr_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: one pending commit expectation and the sticky misalign flag.
    bit          pend = 0;
    logic [4:0]  p_rd;
    logic        p_we;
    logic [31:0] p_data;
    logic        p_fwd;
    logic        m_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (int'(off) * 8)) & 32'h0000_00FF;
        h = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic mis_ref(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return off[0];
        return off != 2'b00;
    endfunction

    task automatic scramble_inputs();
        in_rd         = 5'($urandom);
        in_reg_write  = 1'($urandom);
        in_wb_sel     = 2'($urandom);
        in_funct3     = 3'($urandom);
        in_alu_result = $urandom;
        in_pc4        = $urandom;
    endtask

    task automatic check_commit_or_idle();
        if (pend) begin
            check_val("commit_we", writeRegister, p_we);
            check_val("commit_a3", A3, p_rd);
            check_val("commit_wr3", WR3, p_data);
            check_val("commit_fwd_v", fwd_valid, p_fwd);
            if (p_fwd) check_val("commit_fwd_rd", fwd_rd, p_rd);
            check_val("commit_misalign", misalign, m_mis);
            pend = 0;
        end else begin
            check_val("idle_we", writeRegister, 0);
            check_val("idle_fwd_v", fwd_valid, 0);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or in COMMIT of the previous instruction.
    task automatic do_instr(input instr_t t, input int gap);
        logic        is_mem;
        logic        mis;
        logic        fwd;
        logic [31:0] exp;
        check_commit_or_idle();
        for (int g = 0; g < gap; g++) begin
            in_valid   = 1'b0;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            @(negedge clock);
            check_commit_or_idle();
        end
        check_val("accept_rdy", in_ready, 1);
        in_valid      = 1'b1;
        in_rd         = t.rd;
        in_reg_write  = t.rw;
        in_wb_sel     = t.sel;
        in_funct3     = t.f3;
        in_alu_result = t.alu;
        in_pc4        = t.pc4;
        mem_rvalid    = 1'($urandom);
        mem_rdata     = $urandom;
        @(negedge clock);
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        scramble_inputs();
        is_mem = (t.sel == 2'b01);
        fwd    = t.rw && (t.rd != 5'd0);
        mis    = 1'b0;
        if (is_mem) begin
            for (int k = 0; k < t.lat; k++) begin
                check_val("wait_rdy", in_ready, 0);
                check_val("wait_we", writeRegister, 0);
                check_val("wait_fwd_v", fwd_valid, fwd);
                in_valid = 1'($urandom);
                @(negedge clock);
                in_valid = 1'b0;
            end
            check_val("wait_rdy", in_ready, 0);
            mem_rvalid = 1'b1;
            mem_rdata  = t.mdata;
            @(negedge clock);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mis = mis_ref(t.f3, t.alu[1:0]);
            exp = load_ref(t.f3, t.alu[1:0], t.mdata);
            if (mis) m_mis = 1'b1;
        end else begin
            exp = (t.sel == 2'b10) ? t.pc4 : t.alu;
        end
        pend   = 1;
        p_rd   = t.rd;
        p_we   = fwd && !mis;
        p_data = exp;
        p_fwd  = fwd;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        check_commit_or_idle();
        @(negedge clock);
        check_commit_or_idle();
    endtask

    function automatic instr_t mk(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                  input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                                  input logic [31:0] mdata, input int lat);
        instr_t t;
        t.rd = rd; t.rw = rw; t.sel = sel; t.f3 = f3;
        t.alu = alu; t.pc4 = pc4; t.mdata = mdata; t.lat = lat;
        return t;
    endfunction

    initial begin
        instr_t t;
        reset      = 1'b1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        scramble_inputs();
        repeat (2) @(negedge clock);
        check_val("rst_we", writeRegister, 0);
        check_val("rst_a3", A3, 0);
        check_val("rst_wr3", WR3, 0);
        check_val("rst_fwd_v", fwd_valid, 0);
        check_val("rst_fwd_rd", fwd_rd, 0);
        check_val("rst_misalign", misalign, 0);
        check_val("rst_rdy", in_ready, 1);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases.
        do_instr(mk(5'd5, 1, 2'b00, 3'b010, 32'h0000_1234, 32'h0, 32'h0, 0), 0);
        drain();
        do_instr(mk(5'd9, 1, 2'b01, 3'b000, 32'h0000_1002, 32'h0, 32'h0080_FF00, 3), 0);
        check_val("lb_value", p_data, 32'hFFFF_FF80);
        drain();
        do_instr(mk(5'd9, 1, 2'b01, 3'b100, 32'h0000_1002, 32'h0, 32'h0080_FF00, 3), 0);
        check_val("lbu_value", p_data, 32'h0000_0080);
        drain();
        do_instr(mk(5'd1, 1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0, 0), 0);
        check_val("b2b_jal_we", writeRegister, 1);
        do_instr(mk(5'd2, 1, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 0), 0);
        drain();
        do_instr(mk(5'd0, 1, 2'b00, 3'b000, 32'h0000_5555, 32'h0, 32'h0, 0), 0);
        drain();
        do_instr(mk(5'd3, 1, 2'b01, 3'b001, 32'h0000_2001, 32'h0, 32'h1234_8765, 1), 0);
        drain();
        check_val("misalign_sticky", misalign, 1);

        // Randomized stream, mixing back-to-back issue, gaps, load latencies and all funct3 codes.
        for (int i = 0; i < 300; i++) begin
            t.rd    = 5'($urandom);
            t.rw    = ($urandom_range(0, 3) != 0);
            t.sel   = 2'($urandom);
            t.f3    = 3'($urandom);
            t.alu   = $urandom;
            t.pc4   = $urandom;
            t.mdata = $urandom;
            t.lat   = $urandom_range(0, 4);
            do_instr(t, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end
        drain();

        // Reset while waiting on a load, with rvalid arriving in the reset cycle.
        do_instr(mk(5'd7, 1, 2'b01, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2), 0);
        drain();
        if (!m_mis) do_instr(mk(5'd4, 1, 2'b01, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0), 0);
        drain();
        in_valid      = 1'b1;
        in_rd         = 5'd7;
        in_reg_write  = 1'b1;
        in_wb_sel     = 2'b01;
        in_funct3     = 3'b010;
        in_alu_result = 32'h0000_0200;
        @(negedge clock);
        in_valid = 1'b0;
        check_val("pre_rst_fwd_v", fwd_valid, 1);
        check_val("pre_rst_misalign", misalign, 1);
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clock);
        reset      = 1'b0;
        mem_rvalid = 1'b0;
        m_mis      = 1'b0;
        pend       = 0;
        check_val("wrst_we", writeRegister, 0);
        check_val("wrst_a3", A3, 0);
        check_val("wrst_wr3", WR3, 0);
        check_val("wrst_fwd_v", fwd_valid, 0);
        check_val("wrst_fwd_rd", fwd_rd, 0);
        check_val("wrst_misalign", misalign, m_mis);
        check_val("wrst_rdy", in_ready, 1);
        @(negedge clock);
        check_val("post_rst_we", writeRegister, 0);
        check_val("post_rst_rdy", in_ready, 1);
        do_instr(mk(5'd12, 1, 2'b00, 3'b000, 32'h0BAD_CAFE, 32'h0, 32'h0, 0), 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
